// File: rtl/sysid_check_arbiter_if.sv
// Bus bundle between the two read requesters, the sysid slave and sysid_check_arbiter.
// The slave modport is the arbiter's view; master is the requester/testbench view.
interface sysid_check_arbiter_if;
   logic        m0_read;
   logic        m0_address;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m1_read;
   logic        m1_address;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        sys_address;
   logic [31:0] sys_readdata;

   modport slave (
      input  m0_read, m0_address, m1_read, m1_address, sys_readdata,
      output m0_waitrequest, m0_readdata, m1_waitrequest, m1_readdata, sys_address
   );

   modport master (
      output m0_read, m0_address, m1_read, m1_address, sys_readdata,
      input  m0_waitrequest, m0_readdata, m1_waitrequest, m1_readdata, sys_address
   );
endinterface

// File: rtl/sysid_check_arbiter.sv
// Two-requester round-robin arbiter for the sysid slave with a boot-time ID/timestamp check.
// Define SYSID_RECHECK_EN to add periodic re-checks every RECHECK_PERIOD cycles.
module sysid_check_arbiter #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1486773413
`ifdef SYSID_RECHECK_EN
   , parameter logic [23:0] RECHECK_PERIOD   = 24'd5000000
`endif
) (
   input  logic                  clock,
   input  logic                  reset,
   sysid_check_arbiter_if.slave  bus,
   output logic                  check_done,
   output logic                  id_ok,
   output logic [7:0]            mismatch_count
);

   typedef enum logic [2:0] {CHK_ID, CHK_TS, IDLE, ADDR, CAPT, RESP} state_t;

   state_t      state, state_nxt;
   logic [1:0]  phase, phase_nxt;
   logic        gnt, gnt_nxt;
   logic        gnt_addr, gnt_addr_nxt;
   logic        last, last_nxt;
   logic        id_match, id_match_nxt;
   logic        ts_match, ts_match_nxt;
   logic        sys_addr, sys_addr_nxt;
   logic        wait0, wait0_nxt;
   logic        wait1, wait1_nxt;
   logic [31:0] rdata0, rdata0_nxt;
   logic [31:0] rdata1, rdata1_nxt;
   logic        done_nxt;
   logic        ok_nxt;
   logic [7:0]  mcount_nxt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

`ifdef SYSID_RECHECK_EN
   logic [23:0] rc_cnt;
   logic        recheck_pending;
   logic        recheck_take;

   // A terminal count while a recheck is already pending is absorbed into the same flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         rc_cnt          <= 24'd0;
         recheck_pending <= 1'b0;
      end else if (rc_cnt == RECHECK_PERIOD - 24'd1) begin
         rc_cnt          <= 24'd0;
         recheck_pending <= 1'b1;
      end else begin
         rc_cnt <= rc_cnt + 24'd1;
         if (recheck_take) recheck_pending <= 1'b0;
      end
   end
`endif

   always_comb begin
      state_nxt    = state;
      phase_nxt    = 2'd0;
      gnt_nxt      = gnt;
      gnt_addr_nxt = gnt_addr;
      last_nxt     = last;
      id_match_nxt = id_match;
      ts_match_nxt = ts_match;
      sys_addr_nxt = sys_addr;
      wait0_nxt    = 1'b1;
      wait1_nxt    = 1'b1;
      rdata0_nxt   = rdata0;
      rdata1_nxt   = rdata1;
      done_nxt     = check_done;
      ok_nxt       = id_ok;
      mcount_nxt   = mismatch_count;
`ifdef SYSID_RECHECK_EN
      recheck_take = 1'b0;
`endif
      case (state)
         CHK_ID: begin
            if (phase == 2'd0) begin
               sys_addr_nxt = 1'b0;
               phase_nxt    = 2'd1;
            end else begin
               id_match_nxt = (bus.sys_readdata == EXPECTED_ID);
               state_nxt    = CHK_TS;
            end
         end
         CHK_TS: begin
            if (phase == 2'd0) begin
               sys_addr_nxt = 1'b1;
               phase_nxt    = 2'd1;
            end else if (phase == 2'd1) begin
               ts_match_nxt = (bus.sys_readdata == EXPECTED_TIMESTAMP);
               phase_nxt    = 2'd2;
            end else begin
               ok_nxt    = id_match & ts_match;
               done_nxt  = 1'b1;
               if (!(id_match && ts_match)) mcount_nxt = sat_inc(mismatch_count);
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            // On contention the requester that was not granted last wins.
            if (bus.m0_read || bus.m1_read) begin
               gnt_nxt      = (bus.m0_read && bus.m1_read) ? ~last : bus.m1_read;
               gnt_addr_nxt = gnt_nxt ? bus.m1_address : bus.m0_address;
               last_nxt     = gnt_nxt;
               state_nxt    = ADDR;
            end
`ifdef SYSID_RECHECK_EN
            else if (recheck_pending) begin
               recheck_take = 1'b1;
               state_nxt    = CHK_ID;
            end
`endif
         end
         ADDR: begin
            sys_addr_nxt = gnt_addr;
            state_nxt    = CAPT;
         end
         CAPT: begin
            if (gnt) begin
               rdata1_nxt = bus.sys_readdata;
               wait1_nxt  = 1'b0;
            end else begin
               rdata0_nxt = bus.sys_readdata;
               wait0_nxt  = 1'b0;
            end
            state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = CHK_ID;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= CHK_ID;
         phase          <= 2'd0;
         gnt            <= 1'b0;
         gnt_addr       <= 1'b0;
         last           <= 1'b1;
         id_match       <= 1'b0;
         ts_match       <= 1'b0;
         sys_addr       <= 1'b0;
         wait0          <= 1'b1;
         wait1          <= 1'b1;
         rdata0         <= 32'd0;
         rdata1         <= 32'd0;
         check_done     <= 1'b0;
         id_ok          <= 1'b0;
         mismatch_count <= 8'd0;
      end else begin
         state          <= state_nxt;
         phase          <= phase_nxt;
         gnt            <= gnt_nxt;
         gnt_addr       <= gnt_addr_nxt;
         last           <= last_nxt;
         id_match       <= id_match_nxt;
         ts_match       <= ts_match_nxt;
         sys_addr       <= sys_addr_nxt;
         wait0          <= wait0_nxt;
         wait1          <= wait1_nxt;
         rdata0         <= rdata0_nxt;
         rdata1         <= rdata1_nxt;
         check_done     <= done_nxt;
         id_ok          <= ok_nxt;
         mismatch_count <= mcount_nxt;
      end
   end

   assign bus.sys_address    = sys_addr;
   assign bus.m0_waitrequest = wait0;
   assign bus.m1_waitrequest = wait1;
   assign bus.m0_readdata    = rdata0;
   assign bus.m1_readdata    = rdata1;

endmodule

// File: tb/tb_sysid_check_arbiter.sv
// Self-checking bench for sysid_check_arbiter: boot check, table-driven arbitration vectors,
// reset corner cases and randomized traffic against a transaction-level reference model.
module tb_sysid_check_arbiter;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1486773413;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        check_done, id_ok;
   logic [7:0]  mismatch_count;
   logic [31:0] id_val, ts_val;
   int          n_checks = 0;
   int          n_fail   = 0;

   sysid_check_arbiter_if bif();

   assign bif.sys_readdata = bif.sys_address ? ts_val : id_val;

   sysid_check_arbiter #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bif),
      .check_done     (check_done),
      .id_ok          (id_ok),
      .mismatch_count (mismatch_count)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        r0;
      logic        a0;
      logic        r1;
      logic        a1;
      int          c0;
      int          c1;
      logic [31:0] d0;
      logic [31:0] d1;
   } vec_t;

   vec_t vec [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_wait0"}, bif.m0_waitrequest, 1);
      check({tag, "_wait1"}, bif.m1_waitrequest, 1);
      check({tag, "_rdata0"}, bif.m0_readdata, 0);
      check({tag, "_rdata1"}, bif.m1_readdata, 0);
      check({tag, "_sysaddr"}, bif.sys_address, 0);
      check({tag, "_done"}, check_done, 0);
      check({tag, "_idok"}, id_ok, 0);
      check({tag, "_mcount"}, mismatch_count, 0);
   endtask

   // Pulse reset for two edges and leave the bench at the release negedge.
   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic single_read(input logic which, input logic addr,
                              output int lat, output logic [31:0] data);
      lat  = -1;
      data = 32'd0;
      if (which) begin
         bif.m1_read = 1'b1; bif.m1_address = addr;
      end else begin
         bif.m0_read = 1'b1; bif.m0_address = addr;
      end
      for (int off = 1; off <= 12 && lat < 0; off++) begin
         @(negedge clock);
         if (!which && !bif.m0_waitrequest) begin lat = off; data = bif.m0_readdata; end
         if (which && !bif.m1_waitrequest)  begin lat = off; data = bif.m1_readdata; end
      end
      bif.m0_read = 1'b0;
      bif.m1_read = 1'b0;
   endtask

   initial begin
      int          c0, c1, n0, n1, lat;
      logic [31:0] d0, d1, rd;
      int          free_at, resp_at;
      logic        last_g, pg, r0, r1, a0, a1;
      logic [31:0] pdata, er0, er1;

      vec[0] = '{1'b1, 1'b1, 1'b0, 1'b0,  3, -1, EXP_TS, 32'd0};
      vec[1] = '{1'b0, 1'b0, 1'b1, 1'b0, -1,  3, 32'd0, EXP_ID};
      vec[2] = '{1'b1, 1'b0, 1'b1, 1'b1,  3,  7, EXP_ID, EXP_TS};
      vec[3] = '{1'b0, 1'b0, 1'b1, 1'b1, -1,  3, 32'd0, EXP_TS};
      vec[4] = '{1'b1, 1'b1, 1'b1, 1'b0,  3,  7, EXP_TS, EXP_ID};
      vec[5] = '{1'b1, 1'b0, 1'b0, 1'b0,  3, -1, EXP_ID, 32'd0};
      vec[6] = '{1'b1, 1'b1, 1'b1, 1'b1,  7,  3, EXP_TS, EXP_TS};

      bif.m0_read = 1'b0; bif.m0_address = 1'b0;
      bif.m1_read = 1'b0; bif.m1_address = 1'b0;
      id_val = EXP_ID;
      ts_val = EXP_TS;

      // Boot pass
      repeat (3) @(negedge clock);
      check_reset_values("reset");
      reset = 1'b0;
      repeat (4) @(negedge clock);
      check("boot_done_early", check_done, 0);
      @(negedge clock);
      check("boot_done", check_done, 1);
      check("boot_idok", id_ok, 1);
      check("boot_mcount", mismatch_count, 0);

      // Arbitration vectors
      for (int i = 0; i < 7; i++) begin
         bif.m0_read = vec[i].r0; bif.m0_address = vec[i].a0;
         bif.m1_read = vec[i].r1; bif.m1_address = vec[i].a1;
         c0 = -1; c1 = -1; n0 = 0; n1 = 0; d0 = 32'd0; d1 = 32'd0;
         for (int off = 1; off <= 10; off++) begin
            @(negedge clock);
            if (!bif.m0_waitrequest) begin n0++; c0 = off; d0 = bif.m0_readdata; bif.m0_read = 1'b0; end
            if (!bif.m1_waitrequest) begin n1++; c1 = off; d1 = bif.m1_readdata; bif.m1_read = 1'b0; end
         end
         check($sformatf("vec%0d_m0_cycle", i), c0, vec[i].c0);
         check($sformatf("vec%0d_m1_cycle", i), c1, vec[i].c1);
         check($sformatf("vec%0d_m0_data", i), d0, vec[i].d0);
         check($sformatf("vec%0d_m1_data", i), d1, vec[i].d1);
         check($sformatf("vec%0d_m0_lowcount", i), n0, (vec[i].c0 >= 0) ? 1 : 0);
         check($sformatf("vec%0d_m1_lowcount", i), n1, (vec[i].c1 >= 0) ? 1 : 0);
      end
      @(negedge clock);
      check("hold_rdata0", bif.m0_readdata, EXP_TS);

      // Boot fail
      ts_val = 32'hDEADBEEF;
      pulse_reset();
      repeat (5) @(negedge clock);
      check("fail_done", check_done, 1);
      check("fail_idok", id_ok, 0);
      check("fail_mcount", mismatch_count, 1);
      single_read(1'b0, 1'b1, lat, rd);
      check("fail_read_lat", lat, 3);
      check("fail_read_data", rd, 32'hDEADBEEF);
      ts_val = EXP_TS;

      // Reset during CAPT of an m1 read
      pulse_reset();
      repeat (5) @(negedge clock);
      check("rearm_idok", id_ok, 1);
      bif.m1_read = 1'b1; bif.m1_address = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_reset_values("midop");
      reset = 1'b0;
      lat = -1; rd = 32'd0; d0 = 32'd0;
      for (int off = 1; off <= 20 && lat < 0; off++) begin
         @(negedge clock);
         if (!bif.m1_waitrequest) begin lat = off; rd = bif.m1_readdata; d0 = {31'd0, check_done}; end
      end
      bif.m1_read = 1'b0;
      check("midop_m1_lat", lat, 8);
      check("midop_m1_data", rd, EXP_TS);
      check("midop_done_at_resp", d0, 1);

      // Randomized traffic against a transaction-level model
      id_val = $urandom;
      pulse_reset();
      repeat (5) @(negedge clock);
      check("rnd_boot_done", check_done, 1);
      check("rnd_boot_idok", id_ok, (id_val == EXP_ID) ? 1 : 0);
      check("rnd_boot_mcount", mismatch_count, (id_val == EXP_ID) ? 0 : 1);
      free_at = 0; resp_at = -1; last_g = 1'b1; pg = 1'b0;
      pdata = 32'd0; er0 = 32'd0; er1 = 32'd0;
      for (int k = 0; k < 600; k++) begin
         if (k > 0) @(negedge clock);
         if (k == resp_at) begin
            if (pg) er1 = pdata; else er0 = pdata;
         end
         check("rnd_wait0", bif.m0_waitrequest, (k == resp_at && !pg) ? 0 : 1);
         check("rnd_wait1", bif.m1_waitrequest, (k == resp_at && pg) ? 0 : 1);
         check("rnd_rdata0", bif.m0_readdata, er0);
         check("rnd_rdata1", bif.m1_readdata, er1);
         r0 = ($urandom_range(0, 2) != 0);
         r1 = ($urandom_range(0, 2) != 0);
         a0 = $urandom_range(0, 1) == 1;
         a1 = $urandom_range(0, 1) == 1;
         bif.m0_read = r0; bif.m0_address = a0;
         bif.m1_read = r1; bif.m1_address = a1;
         if (k >= free_at && (r0 || r1)) begin
            pg      = (r0 && r1) ? ~last_g : r1;
            last_g  = pg;
            pdata   = (pg ? a1 : a0) ? ts_val : id_val;
            resp_at = k + 3;
            free_at = k + 4;
         end
      end
      bif.m0_read = 1'b0;
      bif.m1_read = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
